led_code_sender: RTL and testbench

Serial code transmitter for the tri-colour LED: the transmit end of the timed-slot protocol used by the password checker. On a start pulse it latches a code word and plays it out on the LED, one bit per slot, LSB (index 0) first. Frame is a BLUE preamble slot, then one RED (0) or GREEN (1) slot per bit. Every slot is followed by an OFF gap. Used to demo or replay the secret code to the user, and in benches as the stimulus generator for the checker.

---
 rtl/led_code_sender.sv | 166 ++++++++++++++++
 tb/tb_led_code_sender.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_code_sender.sv
// led_code_sender: plays a latched code word out on the active-low RGB LED.
// A frame is one BLUE preamble slot, then one slot per code bit (LSB first):
// RED for 0, GREEN for 1. Each lit slot is followed by an OFF gap.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   S_IDLE    | waiting for start, LED off
//   S_PRE_ON  | preamble slot, LED blue
//   S_PRE_GAP | gap after preamble, LED off
//   S_BIT_ON  | data slot for bit r_bit_idx, LED red/green
//   S_BIT_GAP | gap after data slot, LED off
module led_code_sender #(
    parameter int CODE_WIDTH  = 10,
    parameter int SLOT_CYCLES = 24_000_000,
    parameter int GAP_CYCLES  = 6_000_000
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [CODE_WIDTH-1:0]                 code,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(CODE_WIDTH+1)-1:0]       bit_index,
    output logic [2:0]                            led
);

    localparam int BI_W    = $clog2(CODE_WIDTH + 1);
    localparam int MAX_CYC = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [BI_W-1:0]  BIT_LAST  = BI_W'(CODE_WIDTH - 1);

    localparam logic [2:0] LED_OFF   = 3'b111;
    localparam logic [2:0] LED_RED   = 3'b110;
    localparam logic [2:0] LED_GREEN = 3'b101;
    localparam logic [2:0] LED_BLUE  = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE_ON  = 3'd1,
        S_PRE_GAP = 3'd2,
        S_BIT_ON  = 3'd3,
        S_BIT_GAP = 3'd4
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [BI_W-1:0]       r_bit_idx;
    logic [CODE_WIDTH-1:0] r_code;
    logic                  r_busy;
    logic                  r_done;
    logic [2:0]            r_led;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [BI_W-1:0]       w_bit_nxt;
    logic                  w_accept;
    logic [CODE_WIDTH-1:0] w_code_shift;
    logic [2:0]            w_led_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    // State, slot timer, bit index and latched code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_code    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            if (w_accept) begin
                r_code <= code;
            end
        end
    end

    // Next-state logic; the timer restarts from zero on every state change
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit_idx;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (start) begin
                    w_state_nxt = S_PRE_ON;
                    w_accept    = 1'b1;
                end
            end
            S_PRE_ON: begin
                if (r_cnt == SLOT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = HAS_GAP ? S_PRE_GAP : S_BIT_ON;
                    w_bit_nxt   = '0;
                end
            end
            S_PRE_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BIT_ON;
                    w_bit_nxt   = '0;
                end
            end
            S_BIT_ON, S_BIT_GAP: begin
                if ((r_state == S_BIT_ON) && (r_cnt == SLOT_LAST) && HAS_GAP) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BIT_GAP;
                end else if (((r_state == S_BIT_ON)  && (r_cnt == SLOT_LAST)) ||
                             ((r_state == S_BIT_GAP) && (r_cnt == GAP_LAST))) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx < BIT_LAST) begin
                        w_state_nxt = S_BIT_ON;
                        w_bit_nxt   = r_bit_idx + BI_W'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        w_code_shift = r_code >> w_bit_nxt;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_done_nxt   = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
        case (w_state_nxt)
            S_PRE_ON: w_led_nxt = LED_BLUE;
            S_BIT_ON: w_led_nxt = w_code_shift[0] ? LED_GREEN : LED_RED;
            default:  w_led_nxt = LED_OFF;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_led  <= LED_OFF;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_led  <= w_led_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign bit_index = r_bit_idx;
    assign led       = r_led;

endmodule

// File: tb/tb_led_code_sender.sv
// Bench for led_code_sender: two instances (with gap and zero gap), random
// and directed stimulus, scoreboard of expected frames checked at each done.
module tb_led_code_sender;

    localparam int CW   = 4;
    localparam int S    = 4;
    localparam int GA   = 2;
    localparam int GB   = 0;
    localparam int FL_A = (CW + 1) * (S + GA);
    localparam int FL_B = (CW + 1) * (S + GB);

    typedef struct {
        int code;
        int done_at;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          st_a, st_b;
    logic [CW-1:0] code_a, code_b;
    logic          busy_a, busy_b, done_a, done_b;
    logic [2:0]    bi_a, bi_b;
    logic [2:0]    led_a, led_b;
    logic          fin_req = 1'b0;

    int   cyc = 0;
    int   cl_a = 0;
    int   cl_b = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] tr_led [0:1][0:63];
    int         tr_bi  [0:1][0:63];
    int         tr_len [0:1];
    logic       prev_done [0:1];

    led_code_sender #(.CODE_WIDTH(CW), .SLOT_CYCLES(S), .GAP_CYCLES(GA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(st_a), .code(code_a),
        .busy(busy_a), .done(done_a), .bit_index(bi_a), .led(led_a)
    );

    led_code_sender #(.CODE_WIDTH(CW), .SLOT_CYCLES(S), .GAP_CYCLES(GB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(st_b), .code(code_b),
        .busy(busy_b), .done(done_b), .bit_index(bi_b), .led(led_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level model: a start is taken whenever no frame is outstanding
    task automatic model();
        exp_t e;
        if (cl_a == 0 && st_a) begin
            e.code = int'(code_a); e.done_at = cyc + 1 + FL_A;
            exp_a.push_back(e); cl_a = FL_A;
        end else if (cl_a > 0) cl_a--;
        if (cl_b == 0 && st_b) begin
            e.code = int'(code_b); e.done_at = cyc + 1 + FL_B;
            exp_b.push_back(e); cl_b = FL_B;
        end else if (cl_b > 0) cl_b--;
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        @(negedge clk);
    endtask

    task automatic abort();
        if (cl_a > 0) begin void'(exp_a.pop_back()); cl_a = 0; end
        if (cl_b > 0) begin void'(exp_b.pop_back()); cl_b = 0; end
    endtask

    function automatic logic [2:0] exp_led(int code, int gap, int i);
        int slot, c;
        slot = i / (S + gap);
        c    = i % (S + gap);
        if (c >= S)             return 3'b111;
        if (slot == 0)          return 3'b011;
        if (((code >> (slot - 1)) & 1) != 0) return 3'b101;
        return 3'b110;
    endfunction

    function automatic int exp_bi(int gap, int i);
        int slot;
        slot = i / (S + gap);
        return (slot == 0) ? 0 : slot - 1;
    endfunction

    task automatic chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic mon(int k, logic [2:0] led, logic bsy, logic dn, logic [2:0] bi);
        exp_t e;
        bit   empty;
        int   gap, fl, j;
        string p;
        p   = (k == 0) ? "a" : "b";
        gap = (k == 0) ? GA : GB;
        fl  = (k == 0) ? FL_A : FL_B;
        if (bsy) begin
            if (tr_len[k] < 64) begin
                tr_led[k][tr_len[k]] = led;
                tr_bi[k][tr_len[k]]  = int'(bi);
            end
            tr_len[k]++;
        end
        if (dn) begin
            chk({p, ".done_width"}, int'(prev_done[k]), 0);
            chk({p, ".done_busy"}, int'(bsy), 0);
            chk({p, ".done_led"}, int'(led), 7);
            chk({p, ".done_bidx"}, int'(bi), 0);
            empty = 1'b0;
            if (k == 0) begin
                if (exp_a.size() == 0) empty = 1'b1; else e = exp_a.pop_front();
            end else begin
                if (exp_b.size() == 0) empty = 1'b1; else e = exp_b.pop_front();
            end
            if (empty) begin
                chk({p, ".unexpected_done"}, 1, 0);
            end else begin
                chk({p, ".done_at"}, cyc, e.done_at);
                chk({p, ".busy_len"}, tr_len[k], fl);
                if (tr_len[k] == fl) begin
                    j = 0;
                    for (int i = 0; i < fl; i++)
                        if (tr_led[k][i] != exp_led(e.code, gap, i)) begin j = i; break; end
                    chk($sformatf("%s.led[%0d] code=%0d", p, j, e.code),
                        int'(tr_led[k][j]), int'(exp_led(e.code, gap, j)));
                    j = 0;
                    for (int i = 0; i < fl; i++)
                        if (tr_bi[k][i] != exp_bi(gap, i)) begin j = i; break; end
                    chk($sformatf("%s.bidx[%0d]", p, j), tr_bi[k][j], exp_bi(gap, j));
                end
            end
            tr_len[k] = 0;
        end
        prev_done[k] = dn;
    endtask

    // Monitor: samples mid-cycle, and right after any reset assertion
    initial begin
        tr_len[0] = 0; tr_len[1] = 0;
        prev_done[0] = 1'b0; prev_done[1] = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n or posedge fin_req);
            if (fin_req) begin
                chk("a.left_expected", exp_a.size(), 0);
                chk("b.left_expected", exp_b.size(), 0);
                chk("a.open_trace", tr_len[0], 0);
                chk("b.open_trace", tr_len[1], 0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
            #1;
            if (!rst_n) begin
                chk("a.rst_led", int'(led_a), 7);
                chk("a.rst_busy", int'(busy_a), 0);
                chk("a.rst_done", int'(done_a), 0);
                chk("a.rst_bidx", int'(bi_a), 0);
                chk("b.rst_led", int'(led_b), 7);
                chk("b.rst_busy", int'(busy_b), 0);
                tr_len[0] = 0; tr_len[1] = 0;
                prev_done[0] = 1'b0; prev_done[1] = 1'b0;
            end else begin
                mon(0, led_a, busy_a, done_a, bi_a);
                mon(1, led_b, busy_b, done_b, bi_b);
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0; st_a = 1'b0; st_b = 1'b0; code_a = '0; code_b = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // basic frame on a, zero-gap frame on b
        st_a = 1'b1; code_a = 4'b0110; st_b = 1'b1; code_b = 4'b1111;
        tick();
        st_a = 1'b0; st_b = 1'b0;
        repeat (34) tick();

        // start while busy is ignored
        st_a = 1'b1; code_a = 4'b1001;
        tick();
        st_a = 1'b0;
        repeat (9) tick();
        st_a = 1'b1; code_a = 4'b0000;
        tick();
        st_a = 1'b0;
        repeat (25) tick();

        // back-to-back with start held high; b also sees a changing code
        st_a = 1'b1; code_a = 4'b0001; st_b = 1'b1;
        for (int i = 0; i < 70; i++) begin
            code_b = 4'($urandom);
            tick();
        end
        st_a = 1'b0; st_b = 1'b0;
        repeat (35) tick();

        // code input scrambled during the frame
        st_a = 1'b1; code_a = 4'b1010;
        tick();
        st_a = 1'b0;
        for (int i = 0; i < 33; i++) begin
            code_a = 4'($urandom);
            tick();
        end

        // random traffic
        for (int i = 0; i < 600; i++) begin
            st_a = ($urandom_range(0, 5) == 0); code_a = 4'($urandom);
            st_b = ($urandom_range(0, 5) == 0); code_b = 4'($urandom);
            tick();
        end
        st_a = 1'b0; st_b = 1'b0;
        repeat (35) tick();

        // async reset during the bit 2 slot
        st_a = 1'b1; code_a = 4'($urandom);
        tick();
        st_a = 1'b0;
        repeat (19) tick();
        @(posedge clk);
        model();
        #3 rst_n = 1'b0;
        abort();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        repeat (12) tick();

        // normal operation after reset
        st_a = 1'b1; code_a = 4'($urandom); st_b = 1'b1; code_b = 4'($urandom);
        tick();
        st_a = 1'b0; st_b = 1'b0;
        repeat (35) tick();

        #2 fin_req = 1'b1;
    end

endmodule
